// File: rtl/motoro3_pkg.sv
// Shared types and widths for the motoro3 line PWM drive.
package motoro3_pkg;

  localparam int unsigned StepW = 4;
  localparam int unsigned LenW  = 16;

  localparam logic [LenW-1:0] PwmPeriodDefault = 16'd1000;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StLoad,
    StRun
  } state_e;

endpackage

// File: rtl/motoro3_pwm_period_cnt.sv
// PWM period counter: clock count within a period, period count within a step,
// the on-length compare and the period/step terminal-count flags.
module motoro3_pwm_period_cnt
  import motoro3_pkg::*;
#(
  parameter logic [LenW-1:0] PWM_PERIOD = PwmPeriodDefault
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [LenW-1:0] pl_len_i,
  input  logic [LenW-1:0] sl_len_i,
  output logic            pwm_on_o,
  output logic            period_end_o,
  output logic            step_end_o
);

  logic [LenW-1:0] cnt_q;
  logic [LenW-1:0] per_cnt_q;

  assign pwm_on_o     = (cnt_q < pl_len_i);
  assign period_end_o = (cnt_q == PWM_PERIOD - 1'b1);
  // sl_len_i is never 0 while counting; zero-length steps skip RUN entirely.
  assign step_end_o   = period_end_o && (per_cnt_q == sl_len_i - 1'b1);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q     <= '0;
      per_cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q     <= '0;
      per_cnt_q <= '0;
    end else if (en_i) begin
      if (period_end_o) begin
        cnt_q     <= '0;
        per_cnt_q <= per_cnt_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/motoro3_line_pwm_drive.sv
// Walks lcStep through one electrical line, captures the calculator's plLen/slLen
// per step and emits the PWM waveform for that step.
module motoro3_line_pwm_drive
  import motoro3_pkg::*;
#(
  parameter logic [LenW-1:0]  PWM_PERIOD = PwmPeriodDefault,
  parameter logic [StepW-1:0] STEP_LAST  = 4'd15
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic             stop,
  input  logic             dirRev,
  input  logic             loopEn,
  input  logic [LenW-1:0]  plLen,
  input  logic [LenW-1:0]  slLen,
  output logic [StepW-1:0] lcStep,
  output logic             pwmOut,
  output logic             busy,
  output logic             stepDone,
  output logic             lineDone
);

  state_e          state_q;
  logic            dir_q;
  logic [LenW-1:0] pl_len_q;
  logic [LenW-1:0] sl_len_q;

  logic             pwm_on;
  logic             period_end;
  logic             step_end;
  logic             last_step;
  logic             advance;
  logic [StepW-1:0] first_step;
  logic [StepW-1:0] next_step;

  motoro3_pwm_period_cnt #(
    .PWM_PERIOD(PWM_PERIOD)
  ) u_period_cnt (
    .clk         (clk),
    .nRst        (nRst),
    .clr_i       (state_q == StLoad),
    .en_i        (state_q == StRun),
    .pl_len_i    (pl_len_q),
    .sl_len_i    (sl_len_q),
    .pwm_on_o    (pwm_on),
    .period_end_o(period_end),
    .step_end_o  (step_end)
  );

  always_comb begin
    first_step = dir_q ? STEP_LAST : '0;
    last_step  = dir_q ? (lcStep == '0) : (lcStep == STEP_LAST);
    next_step  = dir_q ? (lcStep - 1'b1) : (lcStep + 1'b1);
    // A zero-period step advances straight out of LOAD.
    advance    = ((state_q == StLoad) && (slLen == '0)) || ((state_q == StRun) && step_end);
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= StIdle;
      dir_q    <= 1'b0;
      pl_len_q <= '0;
      sl_len_q <= '0;
      lcStep   <= '0;
      pwmOut   <= 1'b0;
      stepDone <= 1'b0;
      lineDone <= 1'b0;
    end else begin
      stepDone <= 1'b0;
      lineDone <= 1'b0;
      pwmOut   <= (state_q == StRun) && pwm_on;
      if (stop) begin
        state_q <= StIdle;
        lcStep  <= '0;
        pwmOut  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              dir_q   <= dirRev;
              lcStep  <= dirRev ? STEP_LAST : '0;
              state_q <= StSettle;
            end
          end
          StSettle: state_q <= StLoad;
          StLoad: begin
            pl_len_q <= plLen;
            sl_len_q <= slLen;
            if (slLen != '0) state_q <= StRun;
          end
          StRun: begin
          end
          default: state_q <= StIdle;
        endcase
        if (advance) begin
          stepDone <= 1'b1;
          if (last_step) begin
            lineDone <= 1'b1;
            if (loopEn) begin
              lcStep  <= first_step;
              state_q <= StSettle;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            lcStep  <= next_step;
            state_q <= StSettle;
          end
        end
      end
    end
  end

endmodule
